// File: rtl/config_frame_fsm.sv
// Configuration word-stream decoder: hunts for the sync word, decodes frame
// address words, assembles frame data and issues one frame strobe per frame.
module config_frame_fsm #(
    parameter int          FrameBitsPerRow  = 32,
    parameter int          NumberOfRows     = 16,
    parameter int          MaxFramesPerCol  = 20,
    parameter int          FrameSelectWidth = 5,
    parameter logic [31:0] SyncWord         = 32'hFAB0_FAB1,
    parameter int          DesyncBit        = 20
) (
    input  logic                                      CLK,
    input  logic                                      resetn,
    input  logic [31:0]                               WriteData,
    input  logic                                      WriteStrobe,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
    output logic [FrameSelectWidth-1:0]               FrameSelect,
    output logic                                      FrameStrobe,
    output logic [MaxFramesPerCol-1:0]                FrameIndex_OH,
    output logic                                      Configuring,
    output logic                                      FrameError,
    output logic [1:0]                                DbgState
);

    localparam int FrameWidth  = FrameBitsPerRow * NumberOfRows;
    localparam int RowCntWidth = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [RowCntWidth-1:0] LastRow = RowCntWidth'(NumberOfRows - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                        r_state;
    logic [FrameWidth-1:0]         r_frame_data;
    logic [FrameSelectWidth-1:0]   r_frame_select;
    logic [MaxFramesPerCol-1:0]    r_frame_index_oh;
    logic                          r_frame_strobe;
    logic                          r_frame_error;
    logic                          r_dropped;
    logic [RowCntWidth-1:0]        r_row_cnt;

    logic [FrameSelectWidth-1:0]   w_addr_select;
    logic [FrameSelectWidth-1:0]   w_addr_idx;
    logic                          w_idx_out_of_range;
    logic [MaxFramesPerCol-1:0]    w_idx_oh;
    logic                          w_is_sync;
    logic                          w_is_desync;

    assign w_addr_select      = WriteData[31:32-FrameSelectWidth];
    assign w_addr_idx         = WriteData[FrameSelectWidth-1:0];
    assign w_idx_out_of_range = (32'(w_addr_idx) >= 32'(MaxFramesPerCol));
    assign w_is_sync          = (WriteData == SyncWord);
    assign w_is_desync        = WriteData[DesyncBit];

    // An out-of-range index matches no bit, so the one-hot vector is all zero.
    always_comb begin
        w_idx_oh = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (32'(w_addr_idx) == 32'(i)) begin
                w_idx_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state          <= IDLE;
            r_frame_data     <= '0;
            r_frame_select   <= '0;
            r_frame_index_oh <= '0;
            r_frame_strobe   <= 1'b0;
            r_frame_error    <= 1'b0;
            r_dropped        <= 1'b0;
            r_row_cnt        <= '0;
        end else begin
            r_frame_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (WriteStrobe && w_is_sync) begin
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    // Desync is checked ahead of the sync-word match.
                    if (WriteStrobe) begin
                        if (w_is_desync) begin
                            r_state <= IDLE;
                        end else if (!w_is_sync) begin
                            r_frame_select   <= w_addr_select;
                            r_frame_index_oh <= w_idx_oh;
                            r_dropped        <= w_idx_out_of_range;
                            if (w_idx_out_of_range) begin
                                r_frame_error <= 1'b1;
                            end
                            r_row_cnt <= '0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Sync and desync patterns are plain data here.
                    if (WriteStrobe) begin
                        r_frame_data <= {r_frame_data[FrameWidth-FrameBitsPerRow-1:0], WriteData};
                        r_row_cnt    <= r_row_cnt + RowCntWidth'(1);
                        if (r_row_cnt == LastRow) begin
                            r_state        <= ADDR;
                            r_frame_strobe <= ~r_dropped;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign FrameData     = r_frame_data;
    assign FrameSelect   = r_frame_select;
    assign FrameIndex_OH = r_frame_index_oh;
    assign FrameStrobe   = r_frame_strobe;
    assign FrameError    = r_frame_error;
    assign Configuring   = (r_state != IDLE);
    assign DbgState      = r_state;

endmodule

// File: tb/tb_config_frame_fsm.sv
// Bench for config_frame_fsm: expected frames are queued as they are driven and
// popped when the strobe appears.
module tb_config_frame_fsm;

    localparam int          ROWB  = 32;
    localparam int          ROWS  = 16;
    localparam int          MAXF  = 20;
    localparam int          FSW   = 5;
    localparam int          FW    = ROWB * ROWS;
    localparam int          W     = FSW + MAXF + FW;
    localparam logic [31:0] SYNC  = 32'hFAB0_FAB1;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_ADDR = 2'd1;

    logic            CLK;
    logic            resetn;
    logic [31:0]     WriteData;
    logic            WriteStrobe;
    logic [FW-1:0]   FrameData;
    logic [FSW-1:0]  FrameSelect;
    logic            FrameStrobe;
    logic [MAXF-1:0] FrameIndex_OH;
    logic            Configuring;
    logic            FrameError;
    logic [1:0]      DbgState;

    logic [W-1:0]    exp_q[$];
    logic [31:0]     frame_words[ROWS];
    int              checks = 0;
    int              errors = 0;
    int              strobe_cnt = 0;

    config_frame_fsm dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .WriteData     (WriteData),
        .WriteStrobe   (WriteStrobe),
        .FrameData     (FrameData),
        .FrameSelect   (FrameSelect),
        .FrameStrobe   (FrameStrobe),
        .FrameIndex_OH (FrameIndex_OH),
        .Configuring   (Configuring),
        .FrameError    (FrameError),
        .DbgState      (DbgState)
    );

    // Clock and reset defaults
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (FrameStrobe === 1'b1) strobe_cnt++;
    end

    // Driver tasks
    task automatic send_word(input logic [31:0] w, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            WriteStrobe = 1'b0;
            WriteData   = $urandom;
            @(posedge CLK); #1;
        end
        WriteData   = w;
        WriteStrobe = 1'b1;
        @(posedge CLK); #1;
        WriteStrobe = 1'b0;
        WriteData   = $urandom;
    endtask

    // Sends address plus frame_words; returns 1 time unit after the last word's edge.
    task automatic drive_frame(input logic [FSW-1:0] sel, input int idx, input int max_gap,
                               input bit expect_ok);
        logic [FW-1:0]   d;
        logic [MAXF-1:0] oh;
        logic [4:0]      idx5;
        idx5 = 5'(idx);
        d = '0;
        for (int k = 0; k < ROWS; k++) d[(ROWS-1-k)*ROWB +: ROWB] = frame_words[k];
        oh = (idx < MAXF) ? (MAXF'(1) << idx) : '0;
        if (expect_ok) exp_q.push_back({sel, oh, d});
        send_word({sel, 22'h0, idx5}, max_gap);
        for (int k = 0; k < ROWS; k++) send_word(frame_words[k], max_gap);
    endtask

    task automatic test_reset();
        resetn = 1'b0; WriteStrobe = 1'b1; WriteData = SYNC;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({FrameData, FrameSelect, FrameIndex_OH, FrameStrobe, Configuring, FrameError} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        end
        checks++;
        if (DbgState !== S_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d required %0d", DbgState, S_IDLE);
        end
        resetn = 1'b1; WriteStrobe = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (Configuring !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: got %b required 0", Configuring);
        end
        send_word(SYNC, 0);
        checks++;
        if (Configuring !== 1'b1 || DbgState !== S_ADDR) begin
            errors++; $display("FAIL sync_to_addr: got cfg=%b state=%0d required cfg=1 state=1", Configuring, DbgState);
        end
    endtask

    task automatic test_single_frame();
        logic [W-1:0] e;
        int c0;
        for (int k = 0; k < ROWS; k++) frame_words[k] = 32'(k);
        c0 = strobe_cnt;
        drive_frame(5'd3, 3, 0, 1'b1);
        checks++;
        if (FrameStrobe !== 1'b1) begin
            errors++; $display("FAIL single_strobe: got %b required 1", FrameStrobe);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL single_queue: got empty required 1 entry");
        end else begin
            e = exp_q.pop_front();
            if ({FrameSelect, FrameIndex_OH, FrameData} !== e) begin
                errors++; $display("FAIL single_frame: got sel=%0h oh=%0h required sel=%0h oh=%0h",
                                   FrameSelect, FrameIndex_OH, e[W-1 -: FSW], e[FW +: MAXF]);
            end
        end
        checks++;
        if (FrameSelect !== 5'd3 || FrameIndex_OH !== 20'h00008) begin
            errors++; $display("FAIL single_sel_oh: got %0h/%0h required 3/8", FrameSelect, FrameIndex_OH);
        end
        checks++;
        if (FrameData[31:0] !== 32'hF || FrameData[FW-1 -: 32] !== 32'h0) begin
            errors++; $display("FAIL single_slices: got low=%0h top=%0h required f/0", FrameData[31:0], FrameData[FW-1 -: 32]);
        end
        @(posedge CLK); #1;
        checks++;
        if (FrameStrobe !== 1'b0 || strobe_cnt != c0 + 1) begin
            errors++; $display("FAIL single_one_pulse: got strobe=%b pulses=%0d required 0/1", FrameStrobe, strobe_cnt - c0);
        end
        checks++;
        if (FrameData[31:0] !== 32'hF) begin
            errors++; $display("FAIL data_hold: got %0h required f", FrameData[31:0]);
        end
    endtask

    task automatic test_gapped();
        logic [W-1:0] e;
        int c0;
        for (int k = 0; k < ROWS; k++) frame_words[k] = 32'(k);
        c0 = strobe_cnt;
        drive_frame(5'd3, 3, 3, 1'b1);
        checks++;
        if (FrameStrobe !== 1'b1 || strobe_cnt != c0) begin
            errors++; $display("FAIL gapped_strobe: got %b early=%0d required 1/0", FrameStrobe, strobe_cnt - c0);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL gapped_queue: got empty required 1 entry");
        end else begin
            e = exp_q.pop_front();
            if ({FrameSelect, FrameIndex_OH, FrameData} !== e) begin
                errors++; $display("FAIL gapped_frame: got data_low=%0h required %0h", FrameData[31:0], e[31:0]);
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (strobe_cnt != c0 + 1) begin
            errors++; $display("FAIL gapped_pulses: got %0d required 1", strobe_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        for (int k = 0; k < ROWS; k++) frame_words[k] = $urandom;
        drive_frame(5'd3, 3, 0, 1'b1);
        checks++;
        if (FrameStrobe !== 1'b1 || FrameSelect !== 5'd3) begin
            errors++; $display("FAIL b2b_first: got strobe=%b sel=%0d required 1/3", FrameStrobe, FrameSelect);
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        checks++;
        if ({FrameSelect, FrameIndex_OH, FrameData} !== e) begin
            errors++; $display("FAIL b2b_first_frame: got data_low=%0h required %0h", FrameData[31:0], e[31:0]);
        end
        for (int k = 0; k < ROWS; k++) frame_words[k] = $urandom;
        frame_words[5] = SYNC;
        frame_words[6] = 32'h0010_0000;
        drive_frame(5'd1, 0, 0, 1'b1);
        checks++;
        if (FrameStrobe !== 1'b1) begin
            errors++; $display("FAIL b2b_second_strobe: got %b required 1", FrameStrobe);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_queue: got empty required 1 entry");
        end else begin
            e = exp_q.pop_front();
            if ({FrameSelect, FrameIndex_OH, FrameData} !== e) begin
                errors++; $display("FAIL b2b_second_frame: got sel=%0h oh=%0h required sel=%0h oh=%0h",
                                   FrameSelect, FrameIndex_OH, e[W-1 -: FSW], e[FW +: MAXF]);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_out_of_range();
        logic [W-1:0] e;
        int c0;
        for (int k = 0; k < ROWS; k++) frame_words[k] = $urandom;
        c0 = strobe_cnt;
        drive_frame(5'd2, 25, 1, 1'b0);
        checks++;
        if (FrameError !== 1'b1 || FrameIndex_OH !== '0) begin
            errors++; $display("FAIL oor_error: got err=%b oh=%0h required 1/0", FrameError, FrameIndex_OH);
        end
        checks++;
        if (DbgState !== S_ADDR || FrameStrobe !== 1'b0) begin
            errors++; $display("FAIL oor_state: got state=%0d strobe=%b required 1/0", DbgState, FrameStrobe);
        end
        @(posedge CLK); #1;
        checks++;
        if (strobe_cnt != c0) begin
            errors++; $display("FAIL oor_no_strobe: got %0d pulses required 0", strobe_cnt - c0);
        end
        for (int k = 0; k < ROWS; k++) frame_words[k] = $urandom;
        drive_frame(5'd4, MAXF - 1, 0, 1'b1);
        checks++;
        if (FrameStrobe !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL oor_recover_strobe: got %b required 1", FrameStrobe);
        end else begin
            e = exp_q.pop_front();
            if ({FrameSelect, FrameIndex_OH, FrameData} !== e) begin
                errors++; $display("FAIL oor_recover_frame: got oh=%0h required %0h", FrameIndex_OH, e[FW +: MAXF]);
            end
        end
        checks++;
        if (FrameError !== 1'b1) begin
            errors++; $display("FAIL error_sticky: got %b required 1", FrameError);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_desync();
        send_word(32'h0010_0000, 0);
        checks++;
        if (Configuring !== 1'b0 || DbgState !== S_IDLE) begin
            errors++; $display("FAIL desync_idle: got cfg=%b state=%0d required 0/0", Configuring, DbgState);
        end
        send_word(32'h1800_0003, 0);
        checks++;
        if (DbgState !== S_IDLE) begin
            errors++; $display("FAIL idle_ignore: got state=%0d required 0", DbgState);
        end
    endtask

    task automatic test_mid_frame_reset();
        int c0;
        send_word(SYNC, 0);
        send_word(32'h1800_0003, 0);
        for (int k = 0; k < 7; k++) send_word($urandom, 0);
        c0 = strobe_cnt;
        resetn = 1'b0;
        @(posedge CLK); #1;
        resetn = 1'b1;
        checks++;
        if (FrameData !== '0 || FrameSelect !== '0 || FrameIndex_OH !== '0 || FrameError !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got data_low=%0h sel=%0h err=%b required zeros",
                               FrameData[31:0], FrameSelect, FrameError);
        end
        for (int k = 0; k < 12; k++) send_word($urandom, 0);
        @(posedge CLK); #1;
        checks++;
        if (strobe_cnt != c0 || DbgState !== S_IDLE) begin
            errors++; $display("FAIL midreset_no_strobe: got pulses=%0d state=%0d required 0/0", strobe_cnt - c0, DbgState);
        end
    endtask

    initial begin
        resetn = 1'b0; WriteStrobe = 1'b0; WriteData = '0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_out_of_range();
        test_desync();
        test_mid_frame_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL queue_drained: got %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
